// File: rtl/ws2812_tx.sv
// WS2812 serial LED transmitter: pixels in over a valid/ready handshake, NRZ pulse train out on dout.
// Define WS2812_RGBW_EN for 32-bit GRBW pixels (W byte last); default build uses 24-bit GRB.
module ws2812_tx #(
   parameter int T0H    = 4,
   parameter int T1H    = 8,
   parameter int TBIT   = 13,
   parameter int TRESET = 800,
`ifdef WS2812_RGBW_EN
   localparam int PW    = 32
`else
   localparam int PW    = 24
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [PW-1:0] px_data,
   input  logic          px_last,
   input  logic          px_valid,
   output logic          px_ready,
   output logic          dout,
   output logic          busy,
   output logic          underrun
);

   localparam int CW = $clog2(TRESET + 1);
   localparam int BW = $clog2(PW);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HIGH  = 2'd1;
   localparam logic [1:0] S_LOW   = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   if (!(0 < T0H && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
      $error("ws2812_tx: need 0 < T0H < T1H < TBIT");
   end

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bitcnt_q, bitcnt_d;
   logic          last_q, last_d;
   logic          dout_q, dout_d;
   logic          ready_c, underrun_c;
   logic [CW-1:0] hi_lim, lo_lim;

   // HIGH and LOW lengths are picked from the bit currently at the MSB
   assign hi_lim = shreg_q[PW-1] ? CW'(T1H - 1) : CW'(T0H - 1);
   assign lo_lim = shreg_q[PW-1] ? CW'(TBIT - T1H - 1) : CW'(TBIT - T0H - 1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      bitcnt_d   = bitcnt_q;
      last_d     = last_q;
      ready_c    = 1'b0;
      underrun_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (px_valid) begin
               shreg_d  = px_data;
               last_d   = px_last;
               bitcnt_d = BW'(PW - 1);
               cnt_d    = '0;
               state_d  = S_HIGH;
            end
         end
         S_HIGH: begin
            if (cnt_q == hi_lim) begin
               cnt_d   = '0;
               state_d = S_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LOW: begin
            if (cnt_q != lo_lim) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (bitcnt_q != '0) begin
                  shreg_d  = {shreg_q[PW-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - 1'b1;
                  state_d  = S_HIGH;
               end else if (last_q) begin
                  state_d = S_LATCH;
               end else begin
                  // final cycle of a non-last pixel: a successor must be taken now to avoid a gap
                  ready_c = 1'b1;
                  if (px_valid) begin
                     shreg_d  = px_data;
                     last_d   = px_last;
                     bitcnt_d = BW'(PW - 1);
                     state_d  = S_HIGH;
                  end else begin
                     underrun_c = 1'b1;
                     state_d    = S_LATCH;
                  end
               end
            end
         end
         default: begin
            if (cnt_q == CW'(TRESET - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   assign dout_d = (state_d == S_HIGH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         last_q   <= 1'b0;
         dout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         last_q   <= last_d;
         dout_q   <= dout_d;
      end
   end

   assign px_ready = ready_c & rst_n;
   assign underrun = underrun_c & rst_n;
   assign dout     = dout_q;
   assign busy     = (state_q != S_IDLE);

endmodule
